// File: rtl/cond_unit_if.sv
// Signal bundle between the multicycle main-control FSM and the condition unit.
//   master : FSM/decoder side. Drives Cond, ALUFlags, FlagW and the raw enables
//            NextPC, Branch, RegW, MemW, IRWrite. Receives the gated enables.
//   slave  : condition unit. Receives the raw enables. Drives PCWrite, RegWrite,
//            MemWrite, Flags, CondExR and InstrCount.
interface cond_unit_if #(
  parameter int unsigned CW = 32
);
  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          NextPC;
  logic          Branch;
  logic          RegW;
  logic          MemW;
  logic          IRWrite;
  logic          PCWrite;
  logic          RegWrite;
  logic          MemWrite;
  logic [3:0]    Flags;
  logic          CondExR;
  logic [CW-1:0] InstrCount;

  modport master (
    output Cond, ALUFlags, FlagW, NextPC, Branch, RegW, MemW, IRWrite,
    input  PCWrite, RegWrite, MemWrite, Flags, CondExR, InstrCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, NextPC, Branch, RegW, MemW, IRWrite,
    output PCWrite, RegWrite, MemWrite, Flags, CondExR, InstrCount
  );
endinterface

// File: rtl/cond_unit.sv
// Condition-logic stage behind the multicycle main-control FSM.
// Holds the NZCV flag register, evaluates the ARM condition code against it,
// gates the FSM's raw write enables and counts fetched instructions.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears flags, CondExR and InstrCount
//   bus   : cond_unit_if.slave; inputs Cond, ALUFlags, FlagW, NextPC, Branch,
//           RegW, MemW, IRWrite; outputs PCWrite, RegWrite, MemWrite, Flags,
//           CondExR, InstrCount
module cond_unit #(
  parameter int unsigned CW = 32
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);

  logic [3:0]    flags_q, flags_d;
  logic          condexr_q;
  logic [CW-1:0] count_q;
  logic          cond_ex;
  logic          n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Evaluated against the registered flags, so a flag write in this cycle
  // cannot influence its own condition.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;  // 1111: instruction suppressed
    endcase
  end

  // N,Z and C,V halves are written independently.
  always_comb begin
    flags_d = flags_q;
    if (bus.FlagW[1] && cond_ex) flags_d[3:2] = bus.ALUFlags[3:2];
    if (bus.FlagW[0] && cond_ex) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      condexr_q <= 1'b0;
      count_q   <= '0;
    end else begin
      flags_q   <= flags_d;
      condexr_q <= cond_ex;
      if (bus.IRWrite) count_q <= count_q + CW'(1);  // wraps silently
    end
  end

  // Execute/writeback follow decode by one cycle, so gating uses CondExR.
  // NextPC is never gated so fetch always proceeds.
  assign bus.PCWrite    = bus.NextPC | (bus.Branch & condexr_q);
  assign bus.RegWrite   = bus.RegW & condexr_q;
  assign bus.MemWrite   = bus.MemW & condexr_q;
  assign bus.Flags      = flags_q;
  assign bus.CondExR    = condexr_q;
  assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit (CW=4). Stimulus drives one vector per cycle just after
// the rising edge and queues the outputs expected for that cycle; a monitor
// pops one entry per falling edge and compares the fields selected by its mask.
module tb_cond_unit;

  localparam int unsigned CW = 4;

  localparam logic [5:0] MFlg = 6'h01;
  localparam logic [5:0] MCer = 6'h02;
  localparam logic [5:0] MCnt = 6'h04;
  localparam logic [5:0] MPcw = 6'h08;
  localparam logic [5:0] MRw  = 6'h10;
  localparam logic [5:0] MMw  = 6'h20;
  localparam logic [5:0] MAll = 6'h3f;

  typedef struct {
    string      name;
    logic [5:0] mask;
    logic [3:0] flags;
    logic       cer;
    logic [3:0] cnt;
    logic       pcw;
    logic       rw;
    logic       mw;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   n_tests;
  int   n_fail;

  cond_unit_if #(.CW(CW)) bus ();

  cond_unit #(.CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [3:0] got,
                     input logic [3:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, required %0h", nm, fld, got, req);
    end
  endtask

  // Monitor: compare one queued expectation per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[0]) chk(e.name, "Flags", bus.Flags, e.flags);
      if (e.mask[1]) chk(e.name, "CondExR", {3'b0, bus.CondExR}, {3'b0, e.cer});
      if (e.mask[2]) chk(e.name, "InstrCount", bus.InstrCount, e.cnt);
      if (e.mask[3]) chk(e.name, "PCWrite", {3'b0, bus.PCWrite}, {3'b0, e.pcw});
      if (e.mask[4]) chk(e.name, "RegWrite", {3'b0, bus.RegWrite}, {3'b0, e.rw});
      if (e.mask[5]) chk(e.name, "MemWrite", {3'b0, bus.MemWrite}, {3'b0, e.mw});
    end
  end

  task automatic step(input logic rst, input logic [3:0] cond, input logic [3:0] aluf,
                      input logic [1:0] flagw, input logic npc, input logic br,
                      input logic rw, input logic mw, input logic irw);
    @(posedge clk);
    #1;
    reset        = rst;
    bus.Cond     = cond;
    bus.ALUFlags = aluf;
    bus.FlagW    = flagw;
    bus.NextPC   = npc;
    bus.Branch   = br;
    bus.RegW     = rw;
    bus.MemW     = mw;
    bus.IRWrite  = irw;
  endtask

  task automatic expect_out(input string nm, input logic [5:0] mask, input logic [3:0] fl,
                            input logic cer, input logic [3:0] cnt, input logic pcw,
                            input logic rwr, input logic mwr);
    exp_t e;
    e.name  = nm;
    e.mask  = mask;
    e.flags = fl;
    e.cer   = cer;
    e.cnt   = cnt;
    e.pcw   = pcw;
    e.rw    = rwr;
    e.mw    = mwr;
    q.push_back(e);
  endtask

  // Hand-computed CondEx for all 16 codes (bit i = code i) under each flag value.
  logic [3:0]  tbl_flags [6];
  logic [15:0] tbl_mask  [6];

  initial begin
    tbl_flags[0] = 4'b0000; tbl_mask[0] = 16'h56AA;
    tbl_flags[1] = 4'b0110; tbl_mask[1] = 16'h66A5;
    tbl_flags[2] = 4'b1010; tbl_mask[2] = 16'h6996;
    tbl_flags[3] = 4'b0001; tbl_mask[3] = 16'h6A6A;
    tbl_flags[4] = 4'b1101; tbl_mask[4] = 16'h6659;
    tbl_flags[5] = 4'b0010; tbl_mask[5] = 16'h55A6;
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.Cond = 4'hE; bus.ALUFlags = 4'h0; bus.FlagW = 2'b00;
    bus.NextPC = 1'b0; bus.Branch = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
    bus.IRWrite = 1'b0;

    // Reset, then build Flags=1111 and InstrCount=5 before resetting mid-stream.
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("rst_hold", MAll, 4'h0, 0, 0, 0, 0, 0);
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("rst_hold", MAll, 4'h0, 0, 0, 0, 0, 0);
    step(0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 1); expect_out("rst_rel", MAll, 4'h0, 0, 0, 0, 0, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 1); expect_out("al_write", MAll, 4'hF, 1, 1, 0, 1, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1); expect_out("cnt2", MFlg | MCnt, 4'hF, 0, 2, 0, 0, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1); expect_out("cnt3", MCnt, 4'h0, 0, 3, 0, 0, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1); expect_out("cnt4", MCnt, 4'h0, 0, 4, 0, 0, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1, 0); expect_out("pre_rst", MAll, 4'hF, 1, 5, 0, 1, 1);
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1, 1); expect_out("async_rst", MAll, 4'h0, 0, 0, 0, 0, 0);
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1, 1); expect_out("rst_hold2", MAll, 4'h0, 0, 0, 0, 0, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("after_rst", MAll, 4'h0, 0, 0, 0, 0, 0);

    // Write Z via AL, then NE fails and gates RegW/MemW.
    step(0, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0, 0); expect_out("ne_wr", MFlg | MCer, 4'h0, 1, 0, 0, 0, 0);
    step(0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("ne_flags", MFlg | MCer, 4'h4, 1, 0, 0, 0, 0);
    step(0, 4'h1, 4'h0, 2'b00, 0, 0, 1, 1, 0); expect_out("ne_gate", MAll, 4'h4, 0, 0, 0, 0, 0);

    // LT taken with N=1,V=0; not taken with N=1,V=1; NextPC ungated.
    step(0, 4'hE, 4'h8, 2'b11, 0, 0, 0, 0, 0); expect_out("lt_setup", MFlg | MCer, 4'h4, 0, 0, 0, 0, 0);
    step(0, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("lt_flags", MFlg | MCer, 4'h8, 1, 0, 0, 0, 0);
    step(0, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0, 0); expect_out("lt_taken", MCer | MPcw, 4'h0, 1, 0, 1, 0, 0);
    step(0, 4'hE, 4'h9, 2'b11, 1, 0, 0, 0, 0); expect_out("npc_a", MCer | MPcw, 4'h0, 1, 0, 1, 0, 0);
    step(0, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0, 0);
    expect_out("pre_write_cer", MFlg | MCer | MPcw, 4'h9, 1, 0, 1, 0, 0);
    step(0, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0, 0); expect_out("lt_not", MCer | MPcw, 4'h0, 0, 0, 0, 0, 0);
    step(0, 4'hB, 4'h0, 2'b00, 1, 1, 0, 0, 0); expect_out("npc_b", MCer | MPcw, 4'h0, 0, 0, 1, 0, 0);

    // Partial write of C,V only, then suppressed code 1111.
    step(0, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0); expect_out("clr_setup", MFlg | MCer, 4'h9, 0, 0, 0, 0, 0);
    step(0, 4'hE, 4'hF, 2'b01, 0, 0, 0, 0, 0); expect_out("cv_wr", MFlg | MCer, 4'h0, 1, 0, 0, 0, 0);
    step(0, 4'hF, 4'hF, 2'b11, 0, 0, 0, 0, 0); expect_out("cv_only", MFlg | MCer, 4'h3, 1, 0, 0, 0, 0);
    step(0, 4'hF, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    expect_out("nv_supp", MFlg | MCer | MRw, 4'h3, 0, 0, 0, 0, 0);

    // EQ with a same-cycle N,Z write: condition uses the old Z.
    step(0, 4'hE, 4'h4, 2'b10, 0, 0, 0, 0, 0); expect_out("z_setup", MFlg | MCer, 4'h3, 0, 0, 0, 0, 0);
    step(0, 4'h0, 4'h4, 2'b10, 0, 0, 0, 0, 0); expect_out("eq_wr", MFlg | MCer, 4'h7, 1, 0, 0, 0, 0);
    step(0, 4'h0, 4'h0, 2'b10, 0, 0, 1, 0, 0);
    expect_out("eq_hold", MFlg | MCer | MRw, 4'h7, 1, 0, 0, 1, 0);
    step(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    expect_out("eq_oldflags", MFlg | MCer | MRw, 4'h3, 1, 0, 0, 1, 0);
    step(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    expect_out("eq_now_false", MCer | MRw, 4'h0, 0, 0, 0, 0, 0);

    // Every condition code against several flag values.
    for (int t = 0; t < 6; t++) begin
      logic [15:0] m;
      m = tbl_mask[t];
      step(0, 4'hE, tbl_flags[t], 2'b11, 0, 0, 0, 0, 0);
      expect_out("tbl_load", 6'h00, 4'h0, 0, 0, 0, 0, 0);
      for (int c = 0; c <= 16; c++) begin
        logic [3:0] cc;
        cc = (c < 16) ? 4'(c) : 4'hE;
        step(0, cc, 4'h0, 2'b00, 0, 0, 1, 0, 0);
        if (c == 0) begin
          expect_out($sformatf("tbl_f%0h", tbl_flags[t]), MFlg | MCer, tbl_flags[t], 1, 0, 0, 0, 0);
        end else begin
          expect_out($sformatf("cc%0d_f%0h", c - 1, tbl_flags[t]), MFlg | MCer | MRw,
                     tbl_flags[t], m[c-1], 0, 0, m[c-1], 0);
        end
      end
    end

    // Counter wrap: 17 pulses with idle cycles between them ends at 1.
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("wrap_rst", MCnt, 4'h0, 0, 0, 0, 0, 0);
    step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("wrap_start", MCnt, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 1);
      expect_out($sformatf("wrap_pulse%0d", i), MCnt, 4'h0, 0, 4'(i), 0, 0, 0);
      step(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      expect_out($sformatf("wrap_idle%0d", i), MCnt, 4'h0, 0, 4'(i + 1), 0, 0, 0);
    end
    step(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0); expect_out("wrap_final", MCnt, 4'h0, 0, 1, 0, 0, 0);

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
